// File: rtl/mdio_frame_ctrl.sv
// Clause-22 MDIO frame controller: serialises one read/write management frame
// at a time, generates MDC from a programmable divider and captures read data.
module mdio_frame_ctrl #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_divider,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_mdio_in,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_rd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  half_q, half_d;
  logic [5:0]  hcnt_q, hcnt_d;
  logic        mdc_q, mdc_d;
  logic        busy_q, busy_d;
  logic        oe_q, oe_d;
  logic        mdio_q, mdio_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_err_q, rd_err_d;

  logic        rw_q, rw_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rx_q, rx_d;
  logic        ta_err_q, ta_err_d;

  logic        accept;
  logic        tick;
  logic        fall;
  logic        rise;

  function automatic logic [5:0] state_len(input state_e s);
    case (s)
      S_PRE:   state_len = 6'(PREAMBLE_LEN);
      S_ST:    state_len = 6'd2;
      S_OP:    state_len = 6'd2;
      S_PHY:   state_len = 6'd5;
      S_REG:   state_len = 6'd5;
      S_TA:    state_len = 6'd2;
      S_DATA:  state_len = 6'd16;
      default: state_len = 6'd1;
    endcase
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      S_IDLE:  next_state = (PREAMBLE_LEN > 0) ? S_PRE : S_ST;
      S_PRE:   next_state = S_ST;
      S_ST:    next_state = S_OP;
      S_OP:    next_state = S_PHY;
      S_PHY:   next_state = S_REG;
      S_REG:   next_state = S_TA;
      S_TA:    next_state = S_DATA;
      default: next_state = S_IDLE;
    endcase
  endfunction

  // Bit counter counts down within a field, so it doubles as the MSB-first index.
  function automatic logic frame_bit(input state_e s, input logic [5:0] c,
                                     input logic rw, input logic [4:0] phy,
                                     input logic [4:0] regad, input logic [15:0] wd);
    case (s)
      S_ST:    frame_bit = (c == 6'd0);
      S_OP:    frame_bit = rw ? (c == 6'd1) : (c == 6'd0);
      S_PHY:   frame_bit = phy[c[2:0]];
      S_REG:   frame_bit = regad[c[2:0]];
      S_TA:    frame_bit = rw ? 1'b1 : (c == 6'd1);
      S_DATA:  frame_bit = rw ? 1'b1 : wd[c[3:0]];
      default: frame_bit = 1'b1;
    endcase
  endfunction

  assign accept = i_start && !busy_q;
  assign tick   = busy_q && (hcnt_q == half_q);
  assign fall   = tick && mdc_q;
  assign rise   = tick && !mdc_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      half_q    <= '0;
      hcnt_q    <= '0;
      mdc_q     <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      mdio_q    <= 1'b1;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      hcnt_q    <= hcnt_d;
      mdc_q     <= mdc_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      mdio_q    <= mdio_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rw_q     <= rw_d;
    phy_q    <= phy_d;
    regad_q  <= regad_d;
    wdata_q  <= wdata_d;
    rx_q     <= rx_d;
    ta_err_q <= ta_err_d;
  end

  // Next-state: MDC timing, field sequencing and read sampling
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    hcnt_d    = hcnt_q;
    mdc_d     = mdc_q;
    rw_d      = rw_q;
    phy_d     = phy_q;
    regad_d   = regad_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    ta_err_d  = ta_err_q;
    if (accept) begin
      state_d   = next_state(S_IDLE);
      bit_cnt_d = state_len(state_d) - 6'd1;
      half_d    = (i_divider < 7'd2) ? 6'd1 : i_divider[6:1];
      hcnt_d    = 6'd1;
      mdc_d     = 1'b0;
      rw_d      = i_rw;
      phy_d     = i_phy_addr;
      regad_d   = i_reg_addr;
      wdata_d   = i_wdata;
    end else if (busy_q) begin
      if (tick) begin
        hcnt_d = 6'd1;
        mdc_d  = !mdc_q;
      end else begin
        hcnt_d = hcnt_q + 6'd1;
      end
      if (fall) begin
        if (bit_cnt_q == 6'd0) begin
          state_d   = next_state(state_q);
          bit_cnt_d = (state_d == S_IDLE) ? 6'd0 : state_len(state_d) - 6'd1;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end
      if (rise && rw_q) begin
        if (state_q == S_TA && bit_cnt_q == 6'd0) ta_err_d = i_mdio_in;
        if (state_q == S_DATA) rx_d = {rx_q[14:0], i_mdio_in};
      end
      if (state_d == S_IDLE) hcnt_d = 6'd0;
    end
  end

  // Outputs: the line is released from TA onward on reads
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = fall && (state_q == S_DATA) && (bit_cnt_q == 6'd0);
    oe_d     = busy_d && !(rw_d && (state_d == S_TA || state_d == S_DATA));
    mdio_d   = oe_d ? frame_bit(state_d, bit_cnt_d, rw_d, phy_d, regad_d, wdata_d) : 1'b1;
    rdata_d  = rdata_q;
    rd_err_d = rd_err_q;
    if (done_d && rw_q) begin
      rdata_d  = rx_q;
      rd_err_d = ta_err_q;
    end
  end

  assign o_mdc      = mdc_q;
  assign o_mdio_out = mdio_q;
  assign o_mdio_oe  = oe_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rdata    = rdata_q;
  assign o_rd_err   = rd_err_q;

endmodule

// File: tb/tb_mdio_frame_ctrl.sv
// Scoreboard bench for mdio_frame_ctrl: stimulus pushes expected frames, a
// monitor checks MDC-rise bit capture, timing and read results at o_done.
module tb_mdio_frame_ctrl;

  localparam int P = 32;
  localparam int N = P + 32;

  logic        clk;
  logic        i_rst;
  logic [6:0]  i_divider;
  logic        i_start;
  logic        i_rw;
  logic [4:0]  i_phy_addr;
  logic [4:0]  i_reg_addr;
  logic [15:0] i_wdata;
  logic        i_mdio_in;
  logic        o_mdc, o_mdio_out, o_mdio_oe, o_busy, o_done, o_rd_err;
  logic [15:0] o_rdata;

  mdio_frame_ctrl #(.PREAMBLE_LEN(P)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_divider(i_divider), .i_start(i_start),
    .i_rw(i_rw), .i_phy_addr(i_phy_addr), .i_reg_addr(i_reg_addr),
    .i_wdata(i_wdata), .i_mdio_in(i_mdio_in), .o_mdc(o_mdc),
    .o_mdio_out(o_mdio_out), .o_mdio_oe(o_mdio_oe), .o_busy(o_busy),
    .o_done(o_done), .o_rdata(o_rdata), .o_rd_err(o_rd_err)
  );

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    int unsigned done_cyc;
    int unsigned h;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic [63:0] phy_drv = '1;
  logic [15:0] last_rd = '0;
  logic        last_err = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge with the DUT idle; accept happens at the next posedge.
  task automatic start_frame(input logic rw, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic [6:0] div,
                             input logic ta2, input logic [15:0] rd);
    exp_t e;
    int unsigned h;
    h = (div < 2) ? 1 : div / 2;
    e.bits = {32'hFFFF_FFFF, 2'b01, (rw ? 2'b10 : 2'b01), pa, ra,
              (rw ? 2'b11 : 2'b10), (rw ? 16'hFFFF : wd)};
    e.oe = rw ? {{(P+14){1'b1}}, 18'h0} : {64{1'b1}};
    e.done_cyc = cyc + 1 + N * 2 * h;
    e.h = h;
    if (rw) begin
      last_rd  = rd;
      last_err = ta2;
    end
    e.rdata = last_rd;
    e.err   = last_err;
    phy_drv = rw ? {{(P+15){1'b1}}, ta2, rd} : {64{1'b1}};
    sb.push_back(e);
    i_rw = rw; i_phy_addr = pa; i_reg_addr = ra; i_wdata = wd; i_divider = div;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_accept", o_busy, 1'b1);
    check("oe_after_accept", o_mdio_oe, 1'b1);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!o_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!o_done) check("done_timeout", 1'b0, 1'b1);
  endtask

  // PHY model: changes its driven bit after each MDC falling edge.
  initial begin
    int   idx;
    logic pm;
    idx = 0;
    pm = 1'b0;
    i_mdio_in = 1'b1;
    forever begin
      @(negedge clk);
      if (!o_busy) idx = 0;
      else if (pm && !o_mdc) idx++;
      i_mdio_in = (idx < 64) ? phy_drv[63-idx] : 1'b1;
      pm = o_mdc;
    end
  end

  // Monitor
  initial begin
    logic        prev_mdc;
    logic        capb[$];
    logic        capo[$];
    int unsigned last_tog;
    bit          have_last;
    int          hbad, mism, oem;
    exp_t        e;
    prev_mdc = 1'b0; have_last = 0; hbad = 0; last_tog = 0;
    forever begin
      @(negedge clk);
      if (o_busy && o_mdc && !prev_mdc) begin
        capb.push_back(o_mdio_out);
        capo.push_back(o_mdio_oe);
      end
      if (o_busy && (o_mdc != prev_mdc) && sb.size() > 0) begin
        if (have_last && (cyc - last_tog) != sb[0].h) hbad++;
        last_tog = cyc;
        have_last = 1;
      end
      if (o_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          mism = 0; oem = 0;
          for (int i = 0; i < capb.size() && i < 64; i++) begin
            if (capo[i] !== e.oe[63-i]) oem++;
            if (e.oe[63-i] && capb[i] !== e.bits[63-i]) mism++;
          end
          check("done_cycle", cyc, e.done_cyc);
          check("bit_count", capb.size(), N);
          check("frame_bits", mism, 0);
          check("oe_pattern", oem, 0);
          check("mdc_half_period", hbad, 0);
          check("rdata", o_rdata, e.rdata);
          check("rd_err", o_rd_err, e.err);
          check("end_lines", {o_mdc, o_mdio_oe, o_mdio_out, o_busy}, 4'b0010);
        end
      end
      if (!o_busy) begin
        capb.delete(); capo.delete(); have_last = 0; hbad = 0;
      end
      prev_mdc = o_mdc;
    end
  end

  initial begin
    int dn;
    i_rst = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_phy_addr = '0; i_reg_addr = '0;
    i_wdata = '0; i_divider = 7'd8;
    repeat (3) @(negedge clk);
    check("rst_mdc", o_mdc, 1'b0);
    check("rst_mdio_out", o_mdio_out, 1'b1);
    check("rst_oe", o_mdio_oe, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_rdata", o_rdata, 16'h0);
    check("rst_rd_err", o_rd_err, 1'b0);
    i_rst = 1'b0;
    @(negedge clk);

    // Read aborted by reset at bit 40
    start_frame(1'b1, 5'h03, 5'h02, 16'h0, 7'd4, 1'b0, 16'hABCD);
    repeat (40 * 4) @(negedge clk);
    i_rst = 1'b1;
    sb.delete();
    last_rd = '0; last_err = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort_mdc", o_mdc, 1'b0);
    check("abort_oe", o_mdio_oe, 1'b0);
    check("abort_busy", o_busy, 1'b0);
    check("abort_done", o_done, 1'b0);
    check("abort_rdata", o_rdata, 16'h0);
    dn = 0;
    repeat (300) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    check("abort_no_done", dn, 0);

    // Directed frames, back-to-back after each o_done
    start_frame(1'b0, 5'h01, 5'h00, 16'h1140, 7'd8, 1'b0, 16'h0);
    wait_done(9000);
    start_frame(1'b1, 5'h01, 5'h01, 16'h0, 7'd8, 1'b0, 16'h796D);
    wait_done(9000);
    start_frame(1'b1, 5'h01, 5'h02, 16'h0, 7'd6, 1'b1, 16'hFFFF);
    wait_done(9000);
    start_frame(1'b0, 5'h1F, 5'h1F, 16'hA5A5, 7'd0, 1'b0, 16'h0);
    wait_done(9000);
    start_frame(1'b1, 5'h10, 5'h11, 16'h0, 7'd1, 1'b0, 16'h1234);
    wait_done(9000);
    start_frame(1'b0, 5'h0A, 5'h15, 16'h5A5A, 7'd127, 1'b0, 16'h0);
    wait_done(9000);
    repeat (3) @(negedge clk);

    // Mid-frame disturbance of inputs and a stray start
    start_frame(1'b0, 5'h1A, 5'h05, 16'hBEEF, 7'd6, 1'b0, 16'h0);
    repeat (50) @(negedge clk);
    i_divider = 7'd2; i_wdata = 16'h0123; i_rw = 1'b1; i_phy_addr = 5'h07; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (200) @(negedge clk);
    i_reg_addr = 5'h1C; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(9000);

    // Randomised frames
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
      start_frame(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
                  7'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 16'($urandom));
      wait_done(9000);
    end

    repeat (5) @(negedge clk);
    check("pending_frames", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdio_frame_ctrl.md
Name: mdio_frame_ctrl

Overview:
Clause-22 MDIO management frame controller for PHY initialisation. It accepts one register read or write request at a time and generates the MDC clock from a programmable divider. It serialises the frame onto MDIO and captures read data. It sits between the PHY-init sequencer and the MDC/MDIO pads (tri-state buffer external).

Parameters:
PREAMBLE_LEN, 32, number of preamble '1' bits per frame; legal 0..32 (0 = preamble suppression).

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active high
i_divider  input  7  MDC divider; half-period H = i_divider>>1 clocks, H forced to 1 when i_divider<2
i_start  input  1  request strobe, accepted only when o_busy=0
i_rw  input  1  1=read, 0=write
i_phy_addr  input  5  PHY address
i_reg_addr  input  5  register address
i_wdata  input  16  write data
i_mdio_in  input  1  MDIO pad input
o_mdc  output  1  management clock
o_mdio_out  output  1  MDIO drive value
o_mdio_oe  output  1  MDIO output enable (1=drive)
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse at frame end
o_rdata  output  16  captured read data
o_rd_err  output  1  read turnaround error (PHY did not drive TA bit 2 low)

Behaviour:
- Reset is synchronous and active high, on i_clk. Reset values: o_mdc=0, o_mdio_out=1, o_mdio_oe=0, o_busy=0, o_done=0, o_rdata=0, o_rd_err=0, FSM=IDLE, counters 0.
- Reset mid-frame aborts the frame with no o_done pulse. All outputs take their reset values at that edge.
- Accept: i_start=1 with o_busy=0 at edge k. At that edge latch i_rw, addresses, i_wdata, and H from i_divider; set o_busy=1, o_mdio_oe=1, and o_mdio_out=first frame bit.
- Later changes to the latched inputs are ignored until the next accept. i_start while busy is ignored.
- MDC timing: a half-period counter runs 1..H only while busy; o_mdc toggles when the count reaches H. Each bit is one MDC period of 2H clocks: low for H clocks, then high for H clocks.
- o_mdc is held 0 when idle.
- Drive new bits only on MDC falling edges, i.e. the cycle o_mdc toggles 1->0. Sample i_mdio_in only on MDC rising edges, i.e. the cycle o_mdc toggles 0->1.
- Frame bit order, MSB first:
  - PRE: PREAMBLE_LEN x '1'
  - ST: 01
  - OP: 10 for read, 01 for write
  - PHYAD: 5 bits
  - REGAD: 5 bits
  - TA: write drives "10"; read releases the line
  - DATA: 16 bits
- Total frame length is PREAMBLE_LEN+32 bits.
- FSM states: IDLE -> PRE -> ST -> OP -> PHY -> REG -> TA -> DATA -> IDLE. PRE is skipped when PREAMBLE_LEN=0. A 6-bit bit counter is reloaded on each state entry.
- Read frames:
  - o_mdio_oe=0 from the falling edge that begins TA through the end of DATA.
  - The TA bit-2 sample is stored; o_rd_err is set if that sample is 1.
  - DATA samples shift in MSB first.
  - o_rdata and o_rd_err update at the o_done edge and hold until the next read completes.
  - Data is captured even on error.
- Write frames: o_mdio_oe=1 for the whole frame. o_rdata and o_rd_err are unchanged.
- End of frame: the falling MDC edge that ends the last DATA bit occurs at edge k+(PREAMBLE_LEN+32)*2H. On that edge:
  - o_done=1 for one cycle, o_busy=0
  - o_mdio_oe=0, o_mdio_out=1, o_mdc=0
- A new i_start is accepted at the earliest on the cycle after o_done, which is back-to-back legal.

Test Plan:
- Write frame: i_divider=8 (H=4), PHY 1, reg 0, wdata 0x1140 -> o_mdio_out sequence 32x'1', 01, 01, 00001, 00000, 10, 0001000101000000 sampled at MDC rises; o_mdio_oe=1 throughout; o_done exactly 512 clocks after accept.
- Read frame: PHY model drives TA2=0 and data 0x796D on MDC falling edges -> o_mdio_oe=0 from TA through DATA; o_rdata=0x796D, o_rd_err=0 at o_done.
- Read with no PHY (i_mdio_in=1 constant) -> o_rdata=0xFFFF, o_rd_err=1; o_done still pulses on time.
- i_divider=0, then i_divider=1 (H=1) -> MDC period 2 clocks, frame 128 clocks. i_divider=127 (H=63) -> MDC period 126 clocks.
- i_start pulsed mid-frame, and i_divider/i_wdata changed mid-frame -> no effect on the current frame. Back-to-back start on the cycle after o_done is accepted.
- i_rst asserted at bit 40 of a read -> next cycle o_mdc=0, o_mdio_oe=0, o_busy=0, no o_done, o_rdata unchanged from reset value 0. A subsequent write frame completes normally.
